// File: rtl/prewish_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the FSM state type, the default pattern set and the pattern lookup
// used by the ROM sub-module.
package prewish_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_ERR    = 2'd3
  } prewish_state_e;

  // Largest pattern table the ROM can serve; the index is at most 4 bits.
  localparam int PATTERN_SLOTS = 16;

  // Default patterns, in sequence order; a set bit lights the LED.
  localparam logic [7:0] PAT_0 = 8'hAA;
  localparam logic [7:0] PAT_1 = 8'hF0;
  localparam logic [7:0] PAT_2 = 8'hCC;
  localparam logic [7:0] PAT_3 = 8'h81;

  // Full pattern table. The first four entries are the default set; the rest
  // exist so builds with more patterns still produce a sensible light show.
  function automatic logic [7:0] pattern_lookup(input logic [3:0] idx);
    logic [7:0] pat;
    case (idx)
      4'd0:    pat = PAT_0;
      4'd1:    pat = PAT_1;
      4'd2:    pat = PAT_2;
      4'd3:    pat = PAT_3;
      4'd4:    pat = 8'h55;
      4'd5:    pat = 8'h0F;
      4'd6:    pat = 8'h33;
      4'd7:    pat = 8'h7E;
      4'd8:    pat = 8'h18;
      4'd9:    pat = 8'h24;
      4'd10:   pat = 8'h42;
      4'd11:   pat = 8'h99;
      4'd12:   pat = 8'hC3;
      4'd13:   pat = 8'h3C;
      4'd14:   pat = 8'hE7;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/prewish_pattern_rom.sv
// Combinational pattern ROM: maps a pattern index to its 8-bit LED pattern.
// Indices at or beyond NUM_PATTERNS read as all-off.
module prewish_pattern_rom
  import prewish_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int IDX_W        = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [7:0]       pattern_o
);

  localparam logic [4:0] NUM_PAT_W = 5'(NUM_PATTERNS);

  logic [3:0] idx_ext;

  // Zero-extend the index to the table width, then look up the pattern.
  always_comb begin
    idx_ext              = '0;
    idx_ext[IDX_W-1:0]   = idx_i;
    pattern_o            = 8'h00;
    if ({1'b0, idx_ext} < NUM_PAT_W) begin
      pattern_o = pattern_lookup(idx_ext);
    end
  end

endmodule

// File: rtl/prewish_sequencer.sv
// LED pattern sequencer. Writes each ROM pattern to a bus responder with a
// single-beat strobe, waits for the acknowledge, holds the pattern for
// 2^HOLD_BITS cycles, then moves to the next one. A missing acknowledge
// parks the block in an error state until the next start request.
module prewish_sequencer
  import prewish_pkg::*;
#(
  parameter int HOLD_BITS    = 22,
  parameter int NUM_PATTERNS = 4,
  parameter int ACK_TIMEOUT  = 15,
  parameter int LOOP         = 1
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       go_i,
  input  logic       stop_i,
  input  logic       ACK_I,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
  output logic [7:0] DAT_O,
  output logic       busy_o,
  output logic       err_o
);

  localparam int IDX_W = $clog2(NUM_PATTERNS);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT - 1);

  prewish_state_e       state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 stb_q, stb_d;
  logic                 err_q, err_d;
  logic [7:0]           dat_q, dat_d;
  logic [7:0]           rom_pattern;

  // Pattern for the index the FSM is about to present, so DAT_O is valid on
  // the same edge the strobe rises.
  prewish_pattern_rom #(
    .NUM_PATTERNS (NUM_PATTERNS),
    .IDX_W        (IDX_W)
  ) u_rom (
    .idx_i     (idx_d),
    .pattern_o (rom_pattern)
  );

  // Next-state logic: sequencing, hold counting and acknowledge timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        tmo_d  = '0;
        if (go_i && !stop_i) begin
          state_d = ST_STROBE;
          idx_d   = '0;
        end
      end

      ST_STROBE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          hold_d  = '0;
          tmo_d   = '0;
        end else if (ACK_I) begin
          // An acknowledge on the expiry edge still counts as a success.
          state_d = ST_HOLD;
          hold_d  = '0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LIMIT) begin
          state_d = ST_ERR;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          hold_d  = '0;
          tmo_d   = '0;
        end else if (&hold_q) begin
          hold_d = '0;
          tmo_d  = '0;
          if (idx_q != LAST_IDX) begin
            state_d = ST_STROBE;
            idx_d   = idx_q + 1'b1;
          end else if (LOOP != 0) begin
            state_d = ST_STROBE;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_ERR: begin
        // Only a fresh start leaves the error state; abort is meaningless here.
        hold_d = '0;
        tmo_d  = '0;
        if (go_i) begin
          state_d = ST_STROBE;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        hold_d  = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // Registered bus and status outputs derived from the next state; the data
  // bus only loads while strobing so it keeps the last written pattern.
  always_comb begin
    stb_d = (state_d == ST_STROBE);
    err_d = (state_d == ST_ERR);
    dat_d = dat_q;
    if (state_d == ST_STROBE) begin
      dat_d = rom_pattern;
    end
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign CYC_O  = stb_q;
  assign STB_O  = stb_q;
  assign WE_O   = stb_q;
  assign DAT_O  = dat_q;
  assign busy_o = (state_q == ST_STROBE) || (state_q == ST_HOLD);
  assign err_o  = err_q;

endmodule

// File: tb/tb_prewish_sequencer.sv
// Directed testbench for prewish_sequencer with a short hold and timeout.
// Instance A wraps around (LOOP=1); instance B stops after one pass (LOOP=0).
module tb_prewish_sequencer;

  localparam int HOLD_BITS    = 3;
  localparam int NUM_PATTERNS = 4;
  localparam int ACK_TIMEOUT  = 4;

  logic       clock;
  logic       rstN;
  logic       goA;
  logic       stopA;
  logic       ackManualA;
  logic       ackAutoA;
  logic       ackRespA = 1'b0;
  logic       ackA;
  logic       cycA, stbA, weA, busyA, errA;
  logic [7:0] datA;

  logic       goB;
  logic       ackRespB = 1'b0;
  logic       cycB, stbB, weB, busyB, errB;
  logic [7:0] datB;

  logic [7:0] expPat [4];
  int         vectorCount = 0;
  int         missCount   = 0;

  assign ackA = ackAutoA ? ackRespA : ackManualA;

  prewish_sequencer #(
    .HOLD_BITS    (HOLD_BITS),
    .NUM_PATTERNS (NUM_PATTERNS),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .LOOP         (1)
  ) dut (
    .CLK_I  (clock),
    .RST_I  (rstN),
    .go_i   (goA),
    .stop_i (stopA),
    .ACK_I  (ackA),
    .CYC_O  (cycA),
    .STB_O  (stbA),
    .WE_O   (weA),
    .DAT_O  (datA),
    .busy_o (busyA),
    .err_o  (errA)
  );

  prewish_sequencer #(
    .HOLD_BITS    (HOLD_BITS),
    .NUM_PATTERNS (NUM_PATTERNS),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .LOOP         (0)
  ) dutNoLoop (
    .CLK_I  (clock),
    .RST_I  (rstN),
    .go_i   (goB),
    .stop_i (1'b0),
    .ACK_I  (ackRespB),
    .CYC_O  (cycB),
    .STB_O  (stbB),
    .WE_O   (weB),
    .DAT_O  (datB),
    .busy_o (busyB),
    .err_o  (errB)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Responders: acknowledge one cycle after seeing the strobe.
  always @(negedge clock) begin
    ackRespA = stbA;
    ackRespB = stbB;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic go, input logic stop, input logic ack);
    goA        = go;
    stopA      = stop;
    ackManualA = ack;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Directed stimulus, one step after another.
  initial begin
    expPat     = '{8'hAA, 8'hF0, 8'hCC, 8'h81};
    rstN       = 1'b0;
    goA        = 1'b0;
    stopA      = 1'b0;
    ackManualA = 1'b0;
    ackAutoA   = 1'b0;
    goB        = 1'b0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    checkFlag("rst cyc", cycA, 1'b0);
    checkFlag("rst stb", stbA, 1'b0);
    checkFlag("rst we", weA, 1'b0);
    checkOutput("rst dat", datA, 8'h00);
    checkFlag("rst busy", busyA, 1'b0);
    checkFlag("rst err", errA, 1'b0);
    checkFlag("rst busyB", busyB, 1'b0);
    rstN = 1'b1;
    tick();
    checkFlag("post-rst idle busy", busyA, 1'b0);

    // Full sequence with wrap-around and a go pulse ignored while busy.
    $display("[TB] sequence with automatic acknowledge");
    ackAutoA = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    goA = 1'b0;
    checkFlag("seq0 stb", stbA, 1'b1);
    checkFlag("seq0 cyc", cycA, 1'b1);
    checkFlag("seq0 we", weA, 1'b1);
    checkOutput("seq0 dat", datA, 8'hAA);
    checkFlag("seq0 busy", busyA, 1'b1);
    for (int p = 1; p <= 4; p++) begin
      for (int k = 0; k < 8; k++) begin
        goA = (p == 1 && k == 2);
        tick();
        checkFlag("hold stb", stbA, 1'b0);
        checkOutput("hold dat", datA, expPat[p-1]);
        checkFlag("hold busy", busyA, 1'b1);
      end
      goA = 1'b0;
      tick();
      checkFlag("next stb", stbA, 1'b1);
      checkFlag("next we", weA, 1'b1);
      checkOutput("next dat", datA, expPat[p % 4]);
      checkFlag("next busy", busyA, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    stopA = 1'b0;
    checkFlag("stop-strobe busy", busyA, 1'b0);
    checkFlag("stop-strobe stb", stbA, 1'b0);
    checkFlag("stop-strobe cyc", cycA, 1'b0);
    checkOutput("stop-strobe dat", datA, 8'hAA);

    // Acknowledge never arrives: timeout into the error state.
    $display("[TB] acknowledge timeout");
    ackAutoA = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    goA = 1'b0;
    checkFlag("tmo entry stb", stbA, 1'b1);
    checkOutput("tmo entry dat", datA, 8'hAA);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkFlag("tmo wait stb", stbA, 1'b1);
      checkFlag("tmo wait err", errA, 1'b0);
    end
    tick();
    checkFlag("tmo stb", stbA, 1'b0);
    checkFlag("tmo cyc", cycA, 1'b0);
    checkFlag("tmo we", weA, 1'b0);
    checkFlag("tmo err", errA, 1'b1);
    checkFlag("tmo busy", busyA, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stopA = 1'b0;
    checkFlag("err stop ignored", errA, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    ackManualA = 1'b0;
    checkFlag("err ack ignored", errA, 1'b1);
    checkFlag("err ack stb", stbA, 1'b0);
    ackAutoA = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    goA   = 1'b0;
    stopA = 1'b0;
    checkFlag("err exit err", errA, 1'b0);
    checkFlag("err exit stb", stbA, 1'b1);
    checkOutput("err exit dat", datA, 8'hAA);
    checkFlag("err exit busy", busyA, 1'b1);
    tick();
    checkFlag("err exit hold stb", stbA, 1'b0);

    // Abort during the hold of the third pattern, then restart.
    $display("[TB] abort during hold");
    repeat (8) tick();
    checkFlag("abort p1 stb", stbA, 1'b1);
    checkOutput("abort p1 dat", datA, 8'hF0);
    tick();
    repeat (8) tick();
    checkFlag("abort p2 stb", stbA, 1'b1);
    checkOutput("abort p2 dat", datA, 8'hCC);
    tick();
    checkFlag("abort hold stb", stbA, 1'b0);
    ackAutoA = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkFlag("hold ack ignored stb", stbA, 1'b0);
    checkFlag("hold ack ignored busy", busyA, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stopA = 1'b0;
    checkFlag("abort busy", busyA, 1'b0);
    checkFlag("abort stb", stbA, 1'b0);
    checkOutput("abort dat", datA, 8'hCC);
    repeat (10) tick();
    checkFlag("idle stays busy", busyA, 1'b0);
    checkFlag("idle stays stb", stbA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    ackManualA = 1'b0;
    checkFlag("idle ack ignored", busyA, 1'b0);
    ackAutoA = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    goA = 1'b0;
    checkFlag("restart stb", stbA, 1'b1);
    checkOutput("restart dat", datA, 8'hAA);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stopA = 1'b0;
    checkFlag("restart stop busy", busyA, 1'b0);

    // Acknowledge arrives on the last allowed wait edge.
    $display("[TB] acknowledge on the expiry edge");
    ackAutoA = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    goA = 1'b0;
    checkFlag("late ack entry stb", stbA, 1'b1);
    repeat (3) tick();
    checkFlag("late ack wait stb", stbA, 1'b1);
    checkFlag("late ack wait err", errA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    ackManualA = 1'b0;
    checkFlag("late ack stb", stbA, 1'b0);
    checkFlag("late ack err", errA, 1'b0);
    checkFlag("late ack busy", busyA, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stopA = 1'b0;
    checkFlag("late ack stop busy", busyA, 1'b0);

    // Reset in the middle of a strobe.
    $display("[TB] asynchronous reset mid-strobe");
    applyStimulus(1'b1, 1'b0, 1'b0);
    goA = 1'b0;
    checkFlag("pre-rst stb", stbA, 1'b1);
    checkOutput("pre-rst dat", datA, 8'hAA);
    #2;
    rstN = 1'b0;
    #1;
    checkFlag("async rst cyc", cycA, 1'b0);
    checkFlag("async rst stb", stbA, 1'b0);
    checkFlag("async rst we", weA, 1'b0);
    checkOutput("async rst dat", datA, 8'h00);
    checkFlag("async rst busy", busyA, 1'b0);
    checkFlag("async rst err", errA, 1'b0);
    tick();
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    ackManualA = 1'b0;
    checkFlag("post-rst late ack busy", busyA, 1'b0);
    checkFlag("post-rst late ack stb", stbA, 1'b0);
    checkFlag("post-rst late ack err", errA, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    goA = 1'b0;
    checkFlag("post-rst go stb", stbA, 1'b1);
    checkOutput("post-rst go dat", datA, 8'hAA);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stopA = 1'b0;

    // Single pass without wrap-around.
    $display("[TB] single pass instance");
    goB = 1'b1;
    tick();
    goB = 1'b0;
    checkFlag("noloop stb0", stbB, 1'b1);
    checkOutput("noloop dat0", datB, 8'hAA);
    checkFlag("noloop busy0", busyB, 1'b1);
    for (int p = 1; p <= 3; p++) begin
      repeat (9) tick();
      checkFlag("noloop stb", stbB, 1'b1);
      checkFlag("noloop cyc", cycB, 1'b1);
      checkOutput("noloop dat", datB, expPat[p]);
    end
    repeat (9) tick();
    checkFlag("noloop end busy", busyB, 1'b0);
    checkFlag("noloop end stb", stbB, 1'b0);
    checkOutput("noloop end dat", datB, 8'h81);
    checkFlag("noloop end err", errB, 1'b0);
    repeat (12) tick();
    checkFlag("noloop quiet stb", stbB, 1'b0);
    checkFlag("noloop quiet we", weB, 1'b0);
    checkFlag("noloop quiet busy", busyB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
